// File: rtl/data_ram_pipelined_if.sv
// Request/response bus for data_ram_pipelined.
// master drives requests and consumes responses; slave is the memory.
interface data_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  operation;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BYTES-1:0]      select_signal;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  misaligned;

  modport master (
    output req_valid, operation, addr, select_signal, write_data,
    input  req_ready, resp_valid, read_data, misaligned
  );

  modport slave (
    input  req_valid, operation, addr, select_signal, write_data,
    output req_ready, resp_valid, read_data, misaligned
  );
endinterface

// File: rtl/data_ram_pipelined.sv
// Pipelined data memory for the MIPS memory stage.
// Byte-lane masked writes and reads, valid/ready request side, fixed-latency
// registered response pipeline with no backpressure.
// Optional feature: define RAM_CLEAR_ON_RESET_EN to compile in a post-reset
// sweep that zeroes every word before the first request is accepted.
//
// state    | meaning
// ST_CLEAR | sweep writes 0 to word clr_cnt_q each cycle, req_ready low
// ST_RUN   | normal operation, req_ready high
module data_ram_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_LOG    = 10,
  parameter int READ_LATENCY = 1
) (
  input logic                clock_i,
  input logic                reset_i,
  data_ram_pipelined_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  req_misaligned;
  logic                  wr_en;
  logic [DEPTH_LOG-1:0]  word_idx;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  run_active;
  logic                  unused_addr_bits;

  logic                  pipe_valid_q [READ_LATENCY];
  logic                  pipe_mis_q   [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_q  [READ_LATENCY];

  // Only the word-index and byte-offset bits of addr matter; upper bits wrap.
  assign unused_addr_bits = ^bus.addr;

  assign word_idx       = bus.addr[OFF_W +: DEPTH_LOG];
  assign req_misaligned = |(bus.addr & ADDR_WIDTH'(BYTES - 1));
  assign bus.req_ready  = run_active && !reset_i;
  assign accept         = bus.req_valid && bus.req_ready;
  assign wr_en          = accept && bus.operation && !req_misaligned;

`ifdef RAM_CLEAR_ON_RESET_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [DEPTH_LOG-1:0] clr_cnt_q, clr_cnt_d;
  logic                 clr_we;

  // State and sweep counter register; every reset restarts the sweep.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state: walk every word once, then hand over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign run_active = (state_q == ST_RUN);
  assign clr_we     = (state_q == ST_CLEAR) && !reset_i;

  // Array write port: sweep zeroing or byte-lane masked store.
  always_ff @(posedge clock_i) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.select_signal[b]) mem_q[word_idx][8*b +: 8] <= bus.write_data[8*b +: 8];
      end
    end
  end
`else
  assign run_active = 1'b1;

  // Array write port: byte-lane masked store; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.select_signal[b]) mem_q[word_idx][8*b +: 8] <= bus.write_data[8*b +: 8];
      end
    end
  end
`endif

  // Read data sampled before this edge's write; unselected lanes, writes and
  // misaligned requests all return zero.
  always_comb begin
    rd_data_d = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (bus.select_signal[b]) rd_data_d[8*b +: 8] = mem_q[word_idx][8*b +: 8];
    end
    if (bus.operation || req_misaligned) rd_data_d = '0;
  end

  // Response shift register; reset drops everything in flight.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_mis_q[i]   <= 1'b0;
        pipe_data_q[i]  <= '0;
      end
    end else begin
      pipe_valid_q[0] <= accept;
      pipe_mis_q[0]   <= accept && req_misaligned;
      pipe_data_q[0]  <= accept ? rd_data_d : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_mis_q[i]   <= pipe_mis_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  assign bus.resp_valid = pipe_valid_q[READ_LATENCY-1];
  assign bus.misaligned = pipe_mis_q[READ_LATENCY-1];
  assign bus.read_data  = pipe_data_q[READ_LATENCY-1];
endmodule

// File: tb/tb_data_ram_pipelined.sv
// Directed bench for data_ram_pipelined (READ_LATENCY=3, DEPTH_LOG=10).
module tb_data_ram_pipelined;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DL    = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << DL;
`ifdef RAM_CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  data_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram_if ();

  data_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG(DL), .READ_LATENCY(LAT)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus    (ram_if)
  );

  task automatic issue(input logic op, input logic [31:0] a, input logic [3:0] sel,
                       input logic [31:0] wd);
    @(negedge clk);
    ram_if.req_valid     = 1'b1;
    ram_if.operation     = op;
    ram_if.addr          = a;
    ram_if.select_signal = sel;
    ram_if.write_data    = wd;
    @(negedge clk);
    ram_if.req_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; lat = extra negedges waited, -1 if none.
  task automatic access(input logic op, input logic [31:0] a, input logic [3:0] sel,
                        input logic [31:0] wd, output int lat, output logic [31:0] d,
                        output logic m);
    int i;
    issue(op, a, sel, wd);
    lat = -1; d = '0; m = 1'b0; i = 0;
    while (lat < 0 && i < 10) begin
      if (ram_if.resp_valid === 1'b1) begin
        lat = i; d = ram_if.read_data; m = ram_if.misaligned;
      end else begin
        @(negedge clk);
        i++;
      end
    end
    if (lat >= 0) @(negedge clk);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    #1;
    while (ram_if.req_ready !== 1'b1 && cnt < DEPTH + 10) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    repeat (3) @(negedge clk);
    n_checks++; if (ram_if.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b exp 0", ram_if.resp_valid); else n_pass++;
    n_checks++; if (ram_if.read_data !== 32'h0) $display("FAIL reset_read_data: got %h exp 0", ram_if.read_data); else n_pass++;
    n_checks++; if (ram_if.misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b exp 0", ram_if.misaligned); else n_pass++;
    n_checks++; if (ram_if.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b exp 0", ram_if.req_ready); else n_pass++;
    rst = 1'b0;
    wait_ready(cnt);
    n_checks++; if (cnt != (CLR ? DEPTH : 0)) $display("FAIL reset_ready_delay: got %0d exp %0d", cnt, CLR ? DEPTH : 0); else n_pass++;
  endtask

  task automatic test_full_word();
    int lat; logic [31:0] d; logic m;
    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, d, m);
    n_checks++; if (lat != LAT - 1) $display("FAIL full_wr_latency: got %0d exp %0d", lat, LAT - 1); else n_pass++;
    n_checks++; if (d !== 32'h0) $display("FAIL full_wr_data: got %h exp 0", d); else n_pass++;
    access(1'b0, 32'h10, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (lat != LAT - 1) $display("FAIL full_rd_latency: got %0d exp %0d", lat, LAT - 1); else n_pass++;
    n_checks++; if (d !== 32'hDEADBEEF) $display("FAIL full_rd_data: got %h exp deadbeef", d); else n_pass++;
    n_checks++; if (m !== 1'b0) $display("FAIL full_rd_mis: got %b exp 0", m); else n_pass++;
  endtask

  task automatic test_byte_lane();
    int lat; logic [31:0] d; logic m;
    access(1'b1, 32'h20, 4'hF, 32'h11223344, lat, d, m);
    access(1'b1, 32'h20, 4'h5, 32'hAABBCCDD, lat, d, m);
    access(1'b0, 32'h20, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (d !== 32'h11BB33DD) $display("FAIL lane_rd_f: got %h exp 11bb33dd", d); else n_pass++;
    access(1'b0, 32'h20, 4'hC, 32'h0, lat, d, m);
    n_checks++; if (d !== 32'h11BB0000) $display("FAIL lane_rd_c: got %h exp 11bb0000", d); else n_pass++;
    access(1'b0, 32'h20, 4'h0, 32'h0, lat, d, m);
    n_checks++; if (d !== 32'h0) $display("FAIL lane_rd_0: got %h exp 0", d); else n_pass++;
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] d; logic m;
    access(1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, lat, d, m);
    n_checks++; if (m !== 1'b1) $display("FAIL mis_wr_flag: got %b exp 1", m); else n_pass++;
    n_checks++; if (lat != LAT - 1) $display("FAIL mis_wr_latency: got %0d exp %0d", lat, LAT - 1); else n_pass++;
    access(1'b0, 32'h20, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (d !== 32'h11BB33DD) $display("FAIL mis_mem_unchanged: got %h exp 11bb33dd", d); else n_pass++;
    n_checks++; if (m !== 1'b0) $display("FAIL mis_aligned_flag: got %b exp 0", m); else n_pass++;
    access(1'b0, 32'h23, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (m !== 1'b1) $display("FAIL mis_rd_flag: got %b exp 1", m); else n_pass++;
    n_checks++; if (d !== 32'h0) $display("FAIL mis_rd_data: got %h exp 0", d); else n_pass++;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] d; logic m;
    access(1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A, lat, d, m);
    access(1'b0, 32'h0000, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (d !== 32'h5A5A5A5A) $display("FAIL wrap_rd: got %h exp 5a5a5a5a", d); else n_pass++;
    access(1'b0, 32'h10, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (d !== 32'hDEADBEEF) $display("FAIL wrap_neighbour: got %h exp deadbeef", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic m;
    for (int i = 0; i < 8; i++) access(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), lat, d, m);
    @(negedge clk);
    ram_if.req_valid     = 1'b1;
    ram_if.operation     = 1'b0;
    ram_if.addr          = 32'h100;
    ram_if.select_signal = 4'hF;
    for (int k = 0; k < 8 + LAT; k++) begin
      int  j;
      bit  exp_v;
      @(negedge clk);
      if (k + 1 < 8) ram_if.addr = 32'h100 + 32'(4 * (k + 1));
      else ram_if.req_valid = 1'b0;
      j = k - (LAT - 1);
      exp_v = (j >= 0) && (j < 8);
      n_checks++; if (ram_if.resp_valid !== exp_v) $display("FAIL b2b_valid[%0d]: got %b exp %b", k, ram_if.resp_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_checks++; if (ram_if.read_data !== 32'hC0DE0000 + 32'(j)) $display("FAIL b2b_data[%0d]: got %h exp %h", j, ram_if.read_data, 32'hC0DE0000 + 32'(j)); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    int lat, cnt; logic [31:0] d; logic m;
    @(negedge clk);
    ram_if.req_valid     = 1'b1;
    ram_if.operation     = 1'b0;
    ram_if.addr          = 32'h10;
    ram_if.select_signal = 4'hF;
    @(negedge clk);
    ram_if.addr = 32'h20;
    @(negedge clk);
    ram_if.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      n_checks++; if (ram_if.resp_valid !== 1'b0) $display("FAIL midrst_flushed[%0d]: got %b exp 0", i, ram_if.resp_valid); else n_pass++;
      @(negedge clk);
    end
    wait_ready(cnt);
    access(1'b0, 32'h10, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (d !== (CLR ? 32'h0 : 32'hDEADBEEF)) $display("FAIL midrst_read: got %h exp %h", d, CLR ? 32'h0 : 32'hDEADBEEF); else n_pass++;
    n_checks++; if (lat != LAT - 1) $display("FAIL midrst_latency: got %0d exp %0d", lat, LAT - 1); else n_pass++;
  endtask

  task automatic test_clear_sweep();
    int lat, cnt; logic [31:0] d; logic m;
    access(1'b1, 32'h8, 4'hF, 32'hFFFFFFFF, lat, d, m);
    pulse_reset();
    wait_ready(cnt);
    n_checks++; if (cnt != (CLR ? DEPTH : 0)) $display("FAIL sweep_ready_delay: got %0d exp %0d", cnt, CLR ? DEPTH : 0); else n_pass++;
    access(1'b0, 32'h8, 4'hF, 32'h0, lat, d, m);
    n_checks++; if (d !== (CLR ? 32'h0 : 32'hFFFFFFFF)) $display("FAIL sweep_read: got %h exp %h", d, CLR ? 32'h0 : 32'hFFFFFFFF); else n_pass++;
  endtask

  initial begin
    ram_if.req_valid     = 1'b0;
    ram_if.operation     = 1'b0;
    ram_if.addr          = '0;
    ram_if.select_signal = '0;
    ram_if.write_data    = '0;
    test_reset();
    test_full_word();
    test_byte_lane();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_mid_stream();
    test_clear_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
